// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble),
// one input bit per clock, with a start/ready/done handshake, overflow
// saturation to all nines and a leading-zero blanking mask.
//
// Ports:
//   clk      - system clock, rising edge active
//   rst_n    - asynchronous active-low reset
//   start    - conversion request, honoured only while ready=1
//   bin      - unsigned binary input, captured on the accepting edge
//   ready    - idle and able to accept start
//   done     - one-cycle pulse announcing a new result
//   bcd      - packed BCD result, digit 0 in bits [3:0]
//   overflow - last converted value did not fit in DIGITS digits
//   blank    - bit k set when digit k and all higher digits are zero
module bin2bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] adjusted;
  logic                shifted_out;
  logic [4*DIGITS-1:0] result;
  logic [DIGITS-1:0]   result_blank;
  logic                zero_above;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      dig_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      blank_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    dig_d        = dig_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd_q;
    ovf_d        = ovf_q;
    blank_d      = blank_q;
    done_d       = 1'b0;
    shifted_out  = 1'b0;
    zero_above   = 1'b1;
    result_blank = '0;

    // Any digit of 5 or more would become 10 or more after doubling, so it
    // is pre-biased by 3 to make the doubled value carry into the next digit.
    adjusted = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adjusted[4*k +: 4] > 4'd4) begin
        adjusted[4*k +: 4] = adjusted[4*k +: 4] + 4'd3;
      end
    end

    // A bit ever leaving the top digit means the value needs more digits
    // than we have, so the result saturates.
    result = carry_q ? NINES : dig_q;

    // Blanking walks down from the top digit; bit 0 stays clear so that a
    // zero value still shows a single 0.
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above      = zero_above & (result[4*k +: 4] == 4'd0);
      result_blank[k] = zero_above;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = bin;
          dig_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {shifted_out, dig_d, shift_d} = {adjusted, shift_q, 1'b0};
        carry_d = carry_q | shifted_out;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = result;
        ovf_d   = carry_q;
        blank_d = result_blank;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Exercises three bin2bcd_seq instances (12/4, 16/4 and 14/5 bit/digit
// configurations) sharing one clock and reset. A cycle-level model of the
// handshake and of the decimal result runs alongside and is compared with
// every output of every instance on each falling edge.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;

  // Clock generator, 10 time-unit period.
  always #5 clk = ~clk;

  int bw[3] = '{12, 16, 14};
  int nd[3] = '{4, 4, 5};

  logic   startSig[3];
  longint binVal[3];

  logic [11:0] bin0;
  logic [15:0] bin1;
  logic [13:0] bin2;

  logic        ready0, done0, ovf0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;
  logic        ready1, done1, ovf1;
  logic [15:0] bcd1;
  logic [3:0]  blank1;
  logic        ready2, done2, ovf2;
  logic [19:0] bcd2;
  logic [4:0]  blank2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign bin0 = 12'(binVal[0]);
  assign bin1 = 16'(binVal[1]);
  assign bin2 = 14'(binVal[2]);

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(startSig[0]), .bin(bin0),
    .ready(ready0), .done(done0), .bcd(bcd0), .overflow(ovf0), .blank(blank0)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startSig[1]), .bin(bin1),
    .ready(ready1), .done(done1), .bcd(bcd1), .overflow(ovf1), .blank(blank1)
  );

  bin2bcd_seq #(.BIN_W(14), .DIGITS(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(startSig[2]), .bin(bin2),
    .ready(ready2), .done(done2), .bcd(bcd2), .overflow(ovf2), .blank(blank2)
  );

  // Gather the three differently sized instances into uniform arrays so the
  // checker can loop over them.
  logic        actReady[3], actDone[3], actOvf[3];
  logic [31:0] actBcd[3];
  logic [7:0]  actBlank[3];

  always_comb begin
    actReady[0] = ready0; actDone[0] = done0; actOvf[0] = ovf0;
    actBcd[0] = {16'b0, bcd0}; actBlank[0] = {4'b0, blank0};
    actReady[1] = ready1; actDone[1] = done1; actOvf[1] = ovf1;
    actBcd[1] = {16'b0, bcd1}; actBlank[1] = {4'b0, blank1};
    actReady[2] = ready2; actDone[2] = done2; actOvf[2] = ovf2;
    actBcd[2] = {12'b0, bcd2}; actBlank[2] = {3'b0, blank2};
  end

  // Decimal reference: digits from repeated division, or all nines when the
  // value needs more than d digits.
  function automatic longint pow10(int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] refBcd(longint v, int d);
    logic [31:0] r = '0;
    longint t = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = (v >= pow10(d)) ? 4'h9 : 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit k and everything above it are zero exactly when the displayed
  // value is below 10^k.
  function automatic logic [7:0] refBlank(longint v, int d);
    logic [7:0] r = '0;
    if (v < pow10(d)) begin
      for (int k = 1; k < d; k++) r[k] = (v < pow10(k));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, inst, act, exp, cyc);
    end
  endtask

  // Model state: whether a conversion is outstanding, its value, and the
  // edge on which its result must appear.
  logic        mPend[3];
  longint      mVal[3];
  int          mDoneEdge[3];
  logic        mDone[3];
  logic [31:0] mBcd[3];
  logic        mOvf[3];
  logic [7:0]  mBlank[3];
  int          mAccepts[3];
  int          dutDones[3];
  int          accCyc[3];
  logic        sawOverflow2 = 1'b0;

  // Behavioural model: a request is taken when no conversion is
  // outstanding; its result shows up BIN_W+1 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mPend[i] = 1'b0; mVal[i] = 0; mDoneEdge[i] = 0; mDone[i] = 1'b0;
        mBcd[i] = '0; mOvf[i] = 1'b0; mBlank[i] = '0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        logic acc;
        acc = startSig[i] && !mPend[i];
        mDone[i] = 1'b0;
        if (mPend[i] && cyc == mDoneEdge[i]) begin
          mPend[i]  = 1'b0;
          mDone[i]  = 1'b1;
          mBcd[i]   = refBcd(mVal[i], nd[i]);
          mOvf[i]   = (mVal[i] >= pow10(nd[i]));
          mBlank[i] = refBlank(mVal[i], nd[i]);
        end
        if (acc) begin
          mPend[i]     = 1'b1;
          mVal[i]      = binVal[i] & ((64'sd1 <<< bw[i]) - 1);
          mDoneEdge[i] = cyc + bw[i] + 1;
          mAccepts[i]++;
        end
      end
    end
  end

  // Compare process: every output of every instance against the model on
  // each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checkOutput("ready", i, actReady[i], !mPend[i]);
      checkOutput("done", i, actDone[i], mDone[i]);
      checkOutput("bcd", i, actBcd[i], mBcd[i]);
      checkOutput("overflow", i, actOvf[i], mOvf[i]);
      checkOutput("blank", i, actBlank[i], mBlank[i]);
      if (actDone[i]) dutDones[i]++;
    end
    if (actOvf[2]) sawOverflow2 = 1'b1;
  end

  // Pulse start for one cycle on one instance and remember the accepting edge.
  task automatic applyStimulus(input int inst, input longint v);
    @(posedge clk);
    #1;
    startSig[inst] = 1'b1;
    binVal[inst]   = v;
    @(posedge clk);
    #1;
    accCyc[inst]   = cyc;
    startSig[inst] = 1'b0;
  endtask

  task automatic waitDone(input int inst);
    int n = 0;
    logic found = 1'b0;
    while (n < 60 && !found) begin
      @(negedge clk);
      if (actDone[inst]) found = 1'b1;
      n++;
    end
    if (!found) checkOutput("done_timeout", inst, 0, 1);
  endtask

  task automatic convert(input int inst, input longint v, input longint expBcd,
                         input longint expOvf, input longint expBlank);
    applyStimulus(inst, v);
    waitDone(inst);
    checkOutput("latency", inst, cyc - accCyc[inst], bw[inst] + 1);
    checkOutput("lit_bcd", inst, actBcd[inst], expBcd);
    checkOutput("lit_overflow", inst, actOvf[inst], expOvf);
    checkOutput("lit_blank", inst, actBlank[inst], expBlank);
  endtask

  // Directed sequence followed by a back-to-back random sweep.
  initial begin
    int guard;
    for (int i = 0; i < 3; i++) begin
      startSig[i] = 1'b0; binVal[i] = 0; mAccepts[i] = 0; dutDones[i] = 0;
      accCyc[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 0, ready0, 1);
    checkOutput("rst_done", 0, done0, 0);
    checkOutput("rst_bcd", 0, bcd0, 0);
    checkOutput("rst_blank", 0, blank0, 0);
    rst_n = 1'b1;

    convert(0, 4095, 'h4095, 0, 'b0000);
    checkOutput("lat13", 0, cyc - accCyc[0], 13);
    convert(0, 0, 'h0000, 0, 'b1110);
    convert(0, 7, 'h0007, 0, 'b1110);
    convert(0, 305, 'h0305, 0, 'b1000);

    convert(1, 9999, 'h9999, 0, 'b0000);
    convert(1, 12345, 'h9999, 1, 'b0000);
    convert(1, 65535, 'h9999, 1, 'b0000);

    // A second start three cycles into a conversion must be dropped.
    applyStimulus(0, 100);
    repeat (2) @(posedge clk);
    #1;
    startSig[0] = 1'b1;
    binVal[0]   = 200;
    @(posedge clk);
    #1;
    startSig[0] = 1'b0;
    waitDone(0);
    checkOutput("ignored_bcd", 0, bcd0, 'h0100);

    // Start raised in the done cycle is accepted on the following edge.
    startSig[0] = 1'b1;
    binVal[0]   = 55;
    @(posedge clk);
    #1;
    accCyc[0]   = cyc;
    startSig[0] = 1'b0;
    waitDone(0);
    checkOutput("b2b_latency", 0, cyc - accCyc[0], 13);
    checkOutput("b2b_bcd", 0, bcd0, 'h0055);
    checkOutput("b2b_blank", 0, blank0, 'b1100);

    // Reset in the middle of a conversion.
    applyStimulus(0, 999);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", 0, ready0, 1);
    checkOutput("midrst_bcd", 0, bcd0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    convert(0, 321, 'h0321, 0, 'b1000);

    // Random sweep on the 14-bit/5-digit instance with start held high and
    // bin changing every cycle.
    begin
      int base;
      base = mAccepts[2];
      dutDones[2] = 0;
      guard = 0;
      @(posedge clk);
      #1;
      startSig[2] = 1'b1;
      binVal[2]   = $urandom_range(0, 16383);
      while ((mAccepts[2] - base) < 1000 && guard < 20000) begin
        @(posedge clk);
        #1;
        binVal[2] = $urandom_range(0, 16383);
        guard++;
      end
      startSig[2] = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("sweep_accepts", 2, mAccepts[2] - base, 1000);
      checkOutput("sweep_dones", 2, dutDones[2], 1000);
      checkOutput("sweep_no_overflow", 2, sawOverflow2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
